// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and small helpers used by the
// sync generator and the downstream graphics stage.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_t;

  localparam sync_pol_t SYNC_POL_DEF = SYNC_ACTIVE_LOW;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_clk_en_div.sv
// Clock-enable divider: registered one-clk tick every DIV clocks.
module clk_en_div
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Exposed so the parent can register outputs that must line up with tick.
  assign tick_next = (div_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= tick_next ? '0 : div_cnt + CW'(1);
      tick    <= tick_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, sync pulses, video enable and a
// one-clock end-of-frame strobe, all registered and glitch-free.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic        SYNC_POL  = vga_timing_pkg::SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_end
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] X_FE     = CNT_W'(H_DISPLAY - 1);
  localparam logic [CNT_W-1:0] Y_FE     = CNT_W'(V_DISPLAY - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic             tick_next;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .tick      (pix_tick),
    .tick_next (tick_next)
  );

  always_comb begin
    x_next = x;
    y_next = y;
    if (pix_tick) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = (y == Y_LAST) ? '0 : y + CNT_W'(1);
      end else begin
        x_next = x + CNT_W'(1);
      end
    end
  end

  // Decoding the next-state counters keeps sync/video_on aligned with x/y,
  // and frame_end aligned with the cycle in which pix_tick is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      video_on  <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      hsync     <= in_range(x_next, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync     <= in_range(y_next, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
      video_on  <= (x_next < X_VIS) && (y_next < Y_VIS);
      frame_end <= tick_next && (x_next == X_FE) && (y_next == Y_FE);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a shrunken timing for
// frame-level behaviour, and CLK_DIV=1 with active-high syncs.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst;

  logic       tick_d, hs_d, vs_d, von_d, fe_d;
  logic [9:0] x_d, y_d;
  logic       tick_s, hs_s, vs_s, von_s, fe_s;
  logic [9:0] x_s, y_s;
  logic       tick_p, hs_p, vs_p, von_p, fe_p;
  logic [9:0] x_p, y_p;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fe;
  } exp_t;

  vga_sync_gen u_dut_d (
    .clk (clk), .rst (rst), .pix_tick (tick_d), .x (x_d), .y (y_d),
    .hsync (hs_d), .vsync (vs_d), .video_on (von_d), .frame_end (fe_d)
  );

  vga_sync_gen #(
    .CLK_DIV (3), .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_dut_s (
    .clk (clk), .rst (rst), .pix_tick (tick_s), .x (x_s), .y (y_s),
    .hsync (hs_s), .vsync (vs_s), .video_on (von_s), .frame_end (fe_s)
  );

  vga_sync_gen #(
    .CLK_DIV (1), .SYNC_POL (1'b1)
  ) u_dut_p (
    .clk (clk), .rst (rst), .pix_tick (tick_p), .x (x_p), .y (y_p),
    .hsync (hs_p), .vsync (vs_p), .video_on (von_p), .frame_end (fe_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state n clock edges after reset release: tick is high after
  // edges D, 2D, ...; each such tick advances the position on the next edge.
  function automatic exp_t model(input int n, input int d,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb,
                                 input logic pol);
    exp_t e;
    int   ht, vt, p, ex, ey;
    ht    = hd + hf + hsw + hb;
    vt    = vd + vf + vsw + vb;
    p     = (n >= 1) ? (n - 1) / d : 0;
    ex    = p % ht;
    ey    = (p / ht) % vt;
    e.tick = (n >= 1) && (n % d == 0);
    e.x    = 10'(ex);
    e.y    = 10'(ey);
    e.hs   = (ex >= hd + hf && ex <= hd + hf + hsw - 1) ? pol : ~pol;
    e.vs   = (ey >= vd + vf && ey <= vd + vf + vsw - 1) ? pol : ~pol;
    e.von  = (ex < hd) && (ey < vd);
    e.fe   = e.tick && (ex == hd - 1) && (ey == vd - 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string name, input int n, input exp_t e,
                         input logic tk, input logic [9:0] xv, input logic [9:0] yv,
                         input logic hv, input logic vv, input logic ov, input logic fv);
    chk($sformatf("%s.pix_tick@%0d", name, n), 32'(tk), 32'(e.tick));
    chk($sformatf("%s.x@%0d", name, n), 32'(xv), 32'(e.x));
    chk($sformatf("%s.y@%0d", name, n), 32'(yv), 32'(e.y));
    chk($sformatf("%s.hsync@%0d", name, n), 32'(hv), 32'(e.hs));
    chk($sformatf("%s.vsync@%0d", name, n), 32'(vv), 32'(e.vs));
    chk($sformatf("%s.video_on@%0d", name, n), 32'(ov), 32'(e.von));
    chk($sformatf("%s.frame_end@%0d", name, n), 32'(fv), 32'(e.fe));
  endtask

  task automatic check_at(input int n);
    chk_dut("d", n, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            tick_d, x_d, y_d, hs_d, vs_d, von_d, fe_d);
    chk_dut("s", n, model(n, 3, 8, 2, 3, 2, 5, 1, 2, 1, 1'b0),
            tick_s, x_s, y_s, hs_s, vs_s, von_s, fe_s);
    chk_dut("p", n, model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1),
            tick_p, x_p, y_p, hs_p, vs_p, von_p, fe_p);
  endtask

  initial begin
    int last_fe;
    int fe_cnt;
    int found;
    last_fe = -1;
    fe_cnt  = 0;
    found   = 0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_at(0);
    chk("d.hsync_rst", 32'(hs_d), 32'(1));
    chk("p.hsync_rst", 32'(hs_p), 32'(0));
    rst = 1'b0;
    #1;
    check_at(0);

    for (int n = 1; n <= 1700; n++) begin
      @(posedge clk);
      #1;
      check_at(n);
      if (n == 1) chk("p.tick_first", 32'(tick_p), 32'(1));
      if (n == 1) chk("d.tick_clk1", 32'(tick_d), 32'(0));
      if (n == 2) chk("d.tick_clk2", 32'(tick_d), 32'(1));
      if (n == 3) chk("d.x_first_inc", 32'(x_d), 32'(1));
      if (n == 656) chk("p.hsync_x655", 32'(hs_p), 32'(0));
      if (n == 657) chk("p.hsync_x656", 32'(hs_p), 32'(1));
      if (n == 752) chk("p.hsync_x751", 32'(hs_p), 32'(1));
      if (n == 753) chk("p.hsync_x752", 32'(hs_p), 32'(0));
      if (n == 801) chk("p.line_y", 32'(y_p), 32'(1));
      if (n == 1599) chk("d.x_799", 32'(x_d), 32'(799));
      if (n == 1601) chk("d.x_wrap", 32'(x_d), 32'(0));
      if (n == 1601) chk("d.y_next", 32'(y_d), 32'(1));
      if (n == 204) chk("s.fe_first", 32'(fe_s), 32'(1));
      if (n == 405) chk("s.last_x", 32'(x_s), 32'(14));
      if (n == 405) chk("s.last_y", 32'(y_s), 32'(8));
      if (n == 406) chk("s.wrap_y", 32'(y_s), 32'(0));
      if (n == 406) chk("s.wrap_von", 32'(von_s), 32'(1));
      chk("s.y_below_vtotal", 32'(y_s < 10'd9), 32'(1));
      if (fe_s) begin
        if (last_fe >= 0) chk("s.fe_period", 32'(n - last_fe), 32'(405));
        last_fe = n;
        fe_cnt++;
      end
    end
    chk("s.fe_count", 32'(fe_cnt), 32'(4));

    // Reach x=11, y=3 on the small timing, then reset between clock edges.
    for (int i = 0; i < 500 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (x_s == 10'd11 && y_s == 10'd3) found = 1;
    end
    chk("s.reach_mid_frame", 32'(found), 32'(1));
    #2 rst = 1'b1;
    #1;
    check_at(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_at(0);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      check_at(n);
      if (n == 2) chk("s.tick_early", 32'(tick_s), 32'(0));
      if (n == 3) chk("s.tick_after_rst", 32'(tick_s), 32'(1));
      if (n == 3) chk("s.x_hold", 32'(x_s), 32'(0));
      if (n == 4) chk("s.x_first_inc", 32'(x_s), 32'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
